data_dispatch: RTL



---
 rtl/data_dispatch_pkg.sv | 18 +
 rtl/dispatch_fifo.sv | 83 ++++++++
 rtl/data_dispatch.sv | 101 ++++++++++
 3 files changed

// File: rtl/data_dispatch_pkg.sv
// Shared definitions for the one-to-three data dispatcher.
package data_dispatch_pkg;

  // Width of the destination select field on the upstream bus.
  localparam int DEST_W = 2;

  // Destination codes carried on i_DestSel_D.
  typedef enum logic [DEST_W-1:0] {
    DEST_A    = 2'd0,
    DEST_B    = 2'd1,
    DEST_C    = 2'd2,
    DEST_DROP = 2'd3
  } dest_e;

  // Number of output channels fed by the dispatcher.
  localparam int NUM_CH = 3;

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// The head register keeps its last value while the FIFO is empty, so
// the downstream data bus never shows stale memory contents or X.
module dispatch_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          ASynReset,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_din,
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [WIDTH-1:0]              o_head
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CNT_W-1:0] w_old_left;
  logic [WIDTH-1:0] w_head_next;

  // Full/empty come straight from the registered count, so full is the
  // start-of-cycle value and a same-cycle pop never frees room for a push.
  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_head;

  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign w_rd_next  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_old_left = r_count - CNT_W'(w_pop);

  // Next head: an older entry if one survives the pop, otherwise the word
  // being pushed, otherwise hold the previous value.
  always_comb begin
    w_head_next = r_head;
    if (w_old_left != '0) begin
      w_head_next = r_mem[w_rd_next];
    end else if (w_push) begin
      w_head_next = i_din;
    end
  end

  // Storage array; contents need no reset because pointers gate every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge CLK or posedge ASynReset) begin
    if (ASynReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_next;
      r_head   <= w_head_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_dispatch.sv
// One-to-three dispatcher: routes the upstream D stream into per-channel
// FIFOs by destination tag; each channel handshakes independently.
module data_dispatch
  import data_dispatch_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic              CLK,
  input  logic              ASynReset,
  input  logic              i_DataValid_D,
  input  logic [WIDTH-1:0]  i_DataIn_D,
  input  logic [DEST_W-1:0] i_DestSel_D,
  output logic              o_DataGrant_D,
  output logic              o_DataValid_A,
  output logic [WIDTH-1:0]  o_DataOut_A,
  input  logic              i_DataGrant_A,
  output logic              o_DataValid_B,
  output logic [WIDTH-1:0]  o_DataOut_B,
  input  logic              i_DataGrant_B,
  output logic              o_DataValid_C,
  output logic [WIDTH-1:0]  o_DataOut_C,
  input  logic              i_DataGrant_C,
  output logic [DROP_W-1:0] o_DropCnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_at_cap;
  logic [NUM_CH-1:0] w_ds_grant;
  logic [CNT_W-1:0]  w_count [NUM_CH];
  logic [WIDTH-1:0]  w_head  [NUM_CH];
  logic              w_discard;
  logic              w_drop;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_ds_grant = {i_DataGrant_C, i_DataGrant_B, i_DataGrant_A};

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // A non-full FIFO takes its word even when the global grant is low.
      assign w_push[g]   = i_DataValid_D & (i_DestSel_D == DEST_W'(g)) & ~w_full[g];
      assign w_pop[g]    = ~w_empty[g] & w_ds_grant[g];
      assign w_at_cap[g] = (w_count[g] == CNT_W'(FIFO_DEPTH));

      dispatch_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .CLK       (CLK),
        .ASynReset (ASynReset),
        .i_push    (w_push[g]),
        .i_din     (i_DataIn_D),
        .i_pop     (w_pop[g]),
        .o_full    (w_full[g]),
        .o_empty   (w_empty[g]),
        .o_count   (w_count[g]),
        .o_head    (w_head[g])
      );
    end
  endgenerate

  // Conservative grant: any full channel stalls upstream regardless of tag.
  assign o_DataGrant_D = ~|w_at_cap;

  // A word is discarded when tagged for drop or aimed at a full FIFO.
  always_comb begin
    w_discard = 1'b1;
    case (i_DestSel_D)
      DEST_A:  w_discard = w_full[0];
      DEST_B:  w_discard = w_full[1];
      DEST_C:  w_discard = w_full[2];
      default: w_discard = 1'b1;
    endcase
  end

  assign w_drop = i_DataValid_D & w_discard;

  // Saturating count of discarded words; cleared only by reset.
  always_ff @(posedge CLK or posedge ASynReset) begin
    if (ASynReset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_DropCnt     = r_drop_cnt;
  assign o_DataValid_A = ~w_empty[0];
  assign o_DataValid_B = ~w_empty[1];
  assign o_DataValid_C = ~w_empty[2];
  assign o_DataOut_A   = w_head[0];
  assign o_DataOut_B   = w_head[1];
  assign o_DataOut_C   = w_head[2];

endmodule
